trap_sequencer: RTL and testbench

//  Consumer of the CSR/exception unit's trap requests. On initiate_illinst/initiate_misaligned
//  or a committed MRET it flushes the FD/XB pipeline for a fixed number of cycles, then issues
//  a one-cycle PC redirect: to MTVEC_BASE (direct mode) for traps, or to the sampled mepc for MRET.
//  A fault at the handler entry PC locks the core. Sits between the CSR unit and the fetch stage.

---
 rtl/trap_sequencer.sv | 169 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
// Turns trap requests from the CSR/exception unit, and committed MRETs, into a
// pipeline flush followed by a single-cycle PC redirect to the fetch stage.
// A trap taken while the handler entry itself is in XB locks the core.
//
// Ports
//   clk                 in   clock, rising edge
//   resetb              in   asynchronous active-low reset
//   initiate_illinst    in   illegal-instruction trap request (bubble-gated)
//   initiate_misaligned in   misaligned trap request (bubble-gated)
//   mret                in   MRET decoded in XB
//   XB_bubble           in   XB stage holds a bubble
//   XB_pc               in   PC of the instruction in XB
//   csr_mepc            in   current mepc from the CSR unit
//   flush_FD            out  kill FD-stage instruction
//   flush_XB            out  kill XB-stage instruction
//   redirect_valid      out  one-cycle pulse, fetch loads redirect_pc
//   redirect_pc         out  redirect target, held until the next redirect
//   trap_active         out  sequencer is not idle
//   halted              out  core locked after a fault at the handler entry
//   trap_count          out  saturating count of accepted traps
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a trap request or a committed MRET
// FLUSH    | flush_FD/flush_XB held while the down-counter runs out
// REDIRECT | redirect_valid pulse with the latched target
// LOCKED   | fault at handler entry; flush and halted until reset
// -----------------------------------------------------------------------------
module trap_sequencer #(
    parameter logic [31:0] MTVEC_BASE   = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             initiate_illinst,
    input  logic             initiate_misaligned,
    input  logic             mret,
    input  logic             XB_bubble,
    input  logic [31:0]      XB_pc,
    input  logic [31:0]      csr_mepc,
    output logic             flush_FD,
    output logic             flush_XB,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             trap_active,
    output logic             halted,
    output logic [CNT_W-1:0] trap_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_LOCKED
    } state_t;

    // The counter is loaded with FLUSH_CYCLES-1 because the entry edge
    // already provides the first flush cycle.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic [31:0]        r_target, w_target_nxt;
    logic               r_flush, w_flush_nxt;
    logic               r_redirect_valid, w_redirect_valid_nxt;
    logic [31:0]        r_redirect_pc, w_redirect_pc_nxt;
    logic               r_trap_active, w_trap_active_nxt;
    logic               r_halted, w_halted_nxt;
    logic [CNT_W-1:0]   r_trap_count, w_trap_count_nxt;

    logic               w_trap;
    logic               w_cnt_sat;

    assign w_trap    = initiate_illinst | initiate_misaligned;
    assign w_cnt_sat = &r_trap_count;

    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_target_nxt         = r_target;
        w_flush_nxt          = 1'b0;
        w_redirect_valid_nxt = 1'b0;
        w_redirect_pc_nxt    = r_redirect_pc;
        w_halted_nxt         = 1'b0;
        w_trap_count_nxt     = r_trap_count;

        case (r_state)
            S_IDLE: begin
                if (w_trap) begin
                    if (XB_pc == MTVEC_BASE) begin
                        w_state_nxt  = S_LOCKED;
                        w_flush_nxt  = 1'b1;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_FLUSH;
                        w_flush_nxt  = 1'b1;
                        w_cnt_nxt    = FLUSH_LOAD;
                        w_target_nxt = MTVEC_BASE;
                        if (!w_cnt_sat)
                            w_trap_count_nxt = r_trap_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (mret && !XB_bubble) begin
                    w_state_nxt  = S_FLUSH;
                    w_flush_nxt  = 1'b1;
                    w_cnt_nxt    = FLUSH_LOAD;
                    w_target_nxt = csr_mepc;
                end
            end
            S_FLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt          = S_REDIRECT;
                    w_redirect_valid_nxt = 1'b1;
                    w_redirect_pc_nxt    = r_target;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_flush_nxt = 1'b1;
                end
            end
            S_REDIRECT: begin
                w_state_nxt = S_IDLE;
            end
            S_LOCKED: begin
                w_flush_nxt  = 1'b1;
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_trap_active_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state          <= S_IDLE;
            r_cnt            <= 4'd0;
            r_target         <= 32'd0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_trap_active    <= 1'b0;
            r_halted         <= 1'b0;
            r_trap_count     <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_target         <= w_target_nxt;
            r_flush          <= w_flush_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
            r_trap_active    <= w_trap_active_nxt;
            r_halted         <= w_halted_nxt;
            r_trap_count     <= w_trap_count_nxt;
        end
    end

    assign flush_FD       = r_flush;
    assign flush_XB       = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign trap_active    = r_trap_active;
    assign halted         = r_halted;
    assign trap_count     = r_trap_count;

endmodule

// File: tb/tb_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trap_sequencer
// Directed bench for trap_sequencer. Two instances share all inputs: the main
// one with CNT_W=16 and a second one with CNT_W=2 for counter saturation.
// Status vectors are packed as {flush_FD, flush_XB, redirect_valid,
// trap_active, halted}.
// -----------------------------------------------------------------------------
module tb_trap_sequencer;

    logic        clk;
    logic        resetb;
    logic        initiate_illinst;
    logic        initiate_misaligned;
    logic        mret;
    logic        XB_bubble;
    logic [31:0] XB_pc;
    logic [31:0] csr_mepc;

    logic        flush_FD, flush_XB, redirect_valid, trap_active, halted;
    logic [31:0] redirect_pc;
    logic [15:0] trap_count;

    logic        flush_FD2, flush_XB2, redirect_valid2, trap_active2, halted2;
    logic [31:0] redirect_pc2;
    logic [1:0]  trap_count2;

    int vectors   = 0;
    int miscmp    = 0;

    trap_sequencer #(.MTVEC_BASE(32'h0), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .resetb(resetb),
        .initiate_illinst(initiate_illinst), .initiate_misaligned(initiate_misaligned),
        .mret(mret), .XB_bubble(XB_bubble), .XB_pc(XB_pc), .csr_mepc(csr_mepc),
        .flush_FD(flush_FD), .flush_XB(flush_XB), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_active(trap_active), .halted(halted),
        .trap_count(trap_count)
    );

    trap_sequencer #(.MTVEC_BASE(32'h0), .FLUSH_CYCLES(2), .CNT_W(2)) dut2 (
        .clk(clk), .resetb(resetb),
        .initiate_illinst(initiate_illinst), .initiate_misaligned(initiate_misaligned),
        .mret(mret), .XB_bubble(XB_bubble), .XB_pc(XB_pc), .csr_mepc(csr_mepc),
        .flush_FD(flush_FD2), .flush_XB(flush_XB2), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .trap_active(trap_active2), .halted(halted2),
        .trap_count(trap_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [4:0] st  = {flush_FD, flush_XB, redirect_valid, trap_active, halted};
    wire [4:0] st2 = {flush_FD2, flush_XB2, redirect_valid2, trap_active2, halted2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        #1;
        vectors++;
        if (st !== 5'b00000 || redirect_pc !== 32'h0 || trap_count !== 16'h0) begin
            miscmp++;
            $display("FAIL reset: st=%b pc=%h cnt=%0d, want st=00000 pc=0 cnt=0", st, redirect_pc, trap_count);
        end
        vectors++;
        if (st2 !== 5'b00000 || trap_count2 !== 2'd0) begin
            miscmp++;
            $display("FAIL reset2: st=%b cnt=%0d, want st=00000 cnt=0", st2, trap_count2);
        end
        tick();
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_trap_basic();
        logic [4:0] exp_st [4];
        exp_st = '{5'b11010, 5'b11010, 5'b00110, 5'b00000};
        XB_pc = 32'h40;
        initiate_illinst = 1'b1;
        tick();
        initiate_illinst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (st !== exp_st[i]) begin
                miscmp++;
                $display("FAIL trap_basic step %0d: st=%b, want %b", i, st, exp_st[i]);
            end
            if (i < 3) tick();
        end
        vectors++;
        if (redirect_pc !== 32'h0 || trap_count !== 16'd1) begin
            miscmp++;
            $display("FAIL trap_basic pc/cnt: pc=%h cnt=%0d, want pc=0 cnt=1", redirect_pc, trap_count);
        end
    endtask

    task automatic test_mret();
        XB_bubble = 1'b0;
        csr_mepc  = 32'h124;
        mret      = 1'b1;
        tick();
        mret      = 1'b0;
        csr_mepc  = 32'h200;
        vectors++;
        if (st !== 5'b11010) begin
            miscmp++;
            $display("FAIL mret flush: st=%b, want 11010", st);
        end
        tick();
        tick();
        vectors++;
        if (st !== 5'b00110 || redirect_pc !== 32'h124) begin
            miscmp++;
            $display("FAIL mret redirect: st=%b pc=%h, want st=00110 pc=00000124", st, redirect_pc);
        end
        tick();
        vectors++;
        if (st !== 5'b00000 || redirect_pc !== 32'h124 || trap_count !== 16'd1) begin
            miscmp++;
            $display("FAIL mret after: st=%b pc=%h cnt=%0d, want st=00000 pc=00000124 cnt=1", st, redirect_pc, trap_count);
        end
        // MRET with a bubble in XB must not start a sequence.
        XB_bubble = 1'b1;
        mret      = 1'b1;
        tick();
        mret      = 1'b0;
        XB_bubble = 1'b0;
        vectors++;
        if (st !== 5'b00000) begin
            miscmp++;
            $display("FAIL mret bubble: st=%b, want 00000", st);
        end
    endtask

    task automatic test_both();
        XB_pc    = 32'h80;
        csr_mepc = 32'h300;
        initiate_misaligned = 1'b1;
        mret                = 1'b1;
        tick();
        initiate_misaligned = 1'b0;
        mret                = 1'b0;
        tick();
        tick();
        vectors++;
        if (st !== 5'b00110 || redirect_pc !== 32'h0 || trap_count !== 16'd2) begin
            miscmp++;
            $display("FAIL both redirect: st=%b pc=%h cnt=%0d, want st=00110 pc=0 cnt=2", st, redirect_pc, trap_count);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (st !== 5'b00000 || redirect_pc !== 32'h0) begin
                miscmp++;
                $display("FAIL both no_mret %0d: st=%b pc=%h, want st=00000 pc=0", i, st, redirect_pc);
            end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        test_reset();
        XB_pc = 32'h40;
        for (int k = 0; k < 5; k++) begin
            initiate_illinst = 1'b1;
            tick();
            initiate_illinst = 1'b0;
            vectors++;
            if (trap_count2 !== exp_c[k] || trap_count !== 16'(k + 1)) begin
                miscmp++;
                $display("FAIL saturate trap %0d: cnt2=%0d cnt=%0d, want cnt2=%0d cnt=%0d",
                         k, trap_count2, trap_count, exp_c[k], k + 1);
            end
            if (k == 0) begin
                // Second request arriving mid-FLUSH is ignored.
                initiate_misaligned = 1'b1;
                tick();
                initiate_misaligned = 1'b0;
                vectors++;
                if (trap_count2 !== 2'd1 || st2 !== 5'b11010) begin
                    miscmp++;
                    $display("FAIL saturate midflush: cnt2=%0d st2=%b, want cnt2=1 st2=11010", trap_count2, st2);
                end
                tick();
                vectors++;
                if (st2 !== 5'b00110 || redirect_pc2 !== 32'h0) begin
                    miscmp++;
                    $display("FAIL saturate redirect: st2=%b pc2=%h, want st2=00110 pc2=0", st2, redirect_pc2);
                end
                tick();
                tick();
                vectors++;
                if (st2 !== 5'b00000 || trap_count2 !== 2'd1) begin
                    miscmp++;
                    $display("FAIL saturate no_second: st2=%b cnt2=%0d, want st2=00000 cnt2=1", st2, trap_count2);
                end
            end else begin
                tick();
                tick();
                tick();
            end
        end
    endtask

    task automatic test_lock();
        XB_pc = 32'h0;
        initiate_illinst = 1'b1;
        tick();
        initiate_illinst = 1'b0;
        XB_pc = 32'h40;
        for (int i = 0; i < 120; i++) begin
            vectors++;
            if (st !== 5'b11011 || trap_count !== 16'd5) begin
                miscmp++;
                $display("FAIL lock cycle %0d: st=%b cnt=%0d, want st=11011 cnt=5", i, st, trap_count);
            end
            if (i == 50) initiate_misaligned = 1'b1;
            if (i == 52) initiate_misaligned = 1'b0;
            tick();
        end
        #2;
        resetb = 1'b0;
        #1;
        vectors++;
        if (st !== 5'b00000 || trap_count !== 16'd0) begin
            miscmp++;
            $display("FAIL lock reset: st=%b cnt=%0d, want st=00000 cnt=0", st, trap_count);
        end
        tick();
        resetb = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        XB_pc    = 32'h40;
        csr_mepc = 32'h5A4;
        mret     = 1'b1;
        tick();
        mret     = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (redirect_pc !== 32'h5A4) begin
            miscmp++;
            $display("FAIL async setup pc: pc=%h, want 000005a4", redirect_pc);
        end
        initiate_illinst = 1'b1;
        tick();
        initiate_illinst = 1'b0;
        #2;
        resetb = 1'b0;
        #1;
        vectors++;
        if (st !== 5'b00000 || redirect_pc !== 32'h0 || trap_count !== 16'd0) begin
            miscmp++;
            $display("FAIL async reset: st=%b pc=%h cnt=%0d, want st=00000 pc=0 cnt=0", st, redirect_pc, trap_count);
        end
        #3;
        resetb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (st !== 5'b00000) begin
                miscmp++;
                $display("FAIL async after %0d: st=%b, want 00000", i, st);
            end
        end
    endtask

    initial begin
        resetb              = 1'b0;
        initiate_illinst    = 1'b0;
        initiate_misaligned = 1'b0;
        mret                = 1'b0;
        XB_bubble           = 1'b0;
        XB_pc               = 32'h40;
        csr_mepc            = 32'h0;
        #2;
        test_reset();
        test_trap_basic();
        test_mret();
        test_both();
        test_saturate();
        test_lock();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
